// File: rtl/prog_loader.sv
// prog_loader: framed byte-stream loader that writes 18-bit instruction words into program memory.
// Define PROG_LOADER_CSUM_EN to append and verify an XOR checksum byte after the last word.
module prog_loader #(
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RX_DATA,
  input  logic        RX_VALID,
  output logic        WE,
  output logic [9:0]  WADDR,
  output logic [17:0] WDATA,
  output logic        CPU_HOLD,
  output logic        DONE,
  output logic        ERR
);

  localparam int               TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, CNT_HI, CNT_LO, B2, B1, B0,
`ifdef PROG_LOADER_CSUM_EN
    CSUM
`else
    FIN
`endif
  } state_t;

  state_t           state;
  logic [TMO_W-1:0] tmo;
  logic [1:0]       cnt_hi_p0;
  logic [9:0]       words_left;
  logic [9:0]       addr_cnt;
  logic [1:0]       hi_p0;
  logic [7:0]       mid_p0;
  logic             in_frame;
  logic             tmo_hit;
`ifdef PROG_LOADER_CSUM_EN
  logic [7:0]       csum;
`endif

  // FIN only delays DONE by one cycle; it is not a byte-consuming state.
  always_comb begin
    in_frame = (state != IDLE);
`ifndef PROG_LOADER_CSUM_EN
    if (state == FIN) in_frame = 1'b0;
`endif
    tmo_hit = in_frame && !RX_VALID && (tmo == TMO_LAST);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      tmo        <= '0;
      cnt_hi_p0  <= '0;
      words_left <= '0;
      addr_cnt   <= '0;
      hi_p0      <= '0;
      mid_p0     <= '0;
      WE         <= 1'b0;
      WADDR      <= '0;
      WDATA      <= '0;
      CPU_HOLD   <= 1'b0;
      DONE       <= 1'b0;
      ERR        <= 1'b0;
`ifdef PROG_LOADER_CSUM_EN
      csum       <= '0;
`endif
    end else begin
      WE   <= 1'b0;
      DONE <= 1'b0;

      if (!in_frame || RX_VALID) tmo <= '0;
      else                       tmo <= tmo + TMO_W'(1);

`ifdef PROG_LOADER_CSUM_EN
      if (RX_VALID && in_frame && state != CSUM) csum <= csum ^ RX_DATA;
`endif

      if (tmo_hit) begin
        state    <= IDLE;
        ERR      <= 1'b1;
        CPU_HOLD <= 1'b0;
      end else begin
        case (state)
          IDLE: if (RX_VALID && RX_DATA == SYNC_BYTE) begin
            state    <= CNT_HI;
            ERR      <= 1'b0;
            CPU_HOLD <= 1'b1;
            addr_cnt <= '0;
`ifdef PROG_LOADER_CSUM_EN
            csum     <= '0;
`endif
          end
          CNT_HI: if (RX_VALID) begin
            if (RX_DATA[7:2] != 6'd0) begin
              state    <= IDLE;
              ERR      <= 1'b1;
              CPU_HOLD <= 1'b0;
            end else begin
              cnt_hi_p0 <= RX_DATA[1:0];
              state     <= CNT_LO;
            end
          end
          CNT_LO: if (RX_VALID) begin
            words_left <= {cnt_hi_p0, RX_DATA};
            state      <= B2;
          end
          B2: if (RX_VALID) begin
            hi_p0 <= RX_DATA[1:0];
            state <= B1;
          end
          B1: if (RX_VALID) begin
            mid_p0 <= RX_DATA;
            state  <= B0;
          end
          // p0 -> p1: the completed word is written on the cycle after its last byte
          B0: if (RX_VALID) begin
            WE         <= 1'b1;
            WADDR      <= addr_cnt;
            WDATA      <= {hi_p0, mid_p0, RX_DATA};
            addr_cnt   <= addr_cnt + 10'd1;
            words_left <= words_left - 10'd1;
            if (words_left == 10'd0) begin
`ifdef PROG_LOADER_CSUM_EN
              state <= CSUM;
`else
              state <= FIN;
`endif
            end else begin
              state <= B2;
            end
          end
`ifdef PROG_LOADER_CSUM_EN
          CSUM: if (RX_VALID) begin
            state    <= IDLE;
            CPU_HOLD <= 1'b0;
            if (RX_DATA == csum) DONE <= 1'b1;
            else                 ERR  <= 1'b1;
          end
`else
          FIN: begin
            state    <= IDLE;
            CPU_HOLD <= 1'b0;
            DONE     <= 1'b1;
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed self-checking bench for prog_loader (TIMEOUT_CYC overridden to 16).
// Honours PROG_LOADER_CSUM_EN in the same way as the design.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        we;
  logic [9:0]  waddr;
  logic [17:0] wdata;
  logic        hold;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  prog_loader #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYC(16)) dut (
    .CLK(clk), .RST(rst), .RX_DATA(rx_data), .RX_VALID(rx_valid),
    .WE(we), .WADDR(waddr), .WDATA(wdata), .CPU_HOLD(hold), .DONE(done), .ERR(err)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected {addr, data} writes, consumed as WE pulses appear.
  logic [27:0] exp_q[$];
  logic [27:0] exp_w;
  int          we_cnt = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_we_cyc = 0;
  logic        prev_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      we_cnt++;
      check("we_width", 32'(prev_we), 32'd0);
      check("we_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        exp_w = exp_q.pop_front();
        check("waddr", 32'(waddr), 32'(exp_w[27:18]));
        check("wdata", 32'(wdata), 32'(exp_w[17:0]));
      end
      last_we_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      check("hold_at_done", 32'(hold), 32'd0);
`ifndef PROG_LOADER_CSUM_EN
      check("done_latency", 32'(cyc - last_we_cyc), 32'd1);
`endif
    end
    prev_we = we;
  end

  logic [7:0] sum;
  logic [9:0] nxt_addr;
  int         gap = 0;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    tick(gap);
  endtask

  task automatic send_f(input logic [7:0] b);
    sum = sum ^ b;
    send(b);
  endtask

  task automatic start(input logic [9:0] field);
    send(8'hA5);
    sum      = 8'h00;
    nxt_addr = 10'd0;
    send_f({6'd0, field[9:8]});
    send_f(field[7:0]);
  endtask

  task automatic word(input logic [17:0] d, input logic [5:0] junk);
    exp_q.push_back({nxt_addr, d});
    nxt_addr = nxt_addr + 10'd1;
    send_f({junk, d[17:16]});
    send_f(d[15:8]);
    send_f(d[7:0]);
  endtask

  task automatic finish_frame();
`ifdef PROG_LOADER_CSUM_EN
    send(sum);
`endif
  endtask

  int we0;
  int d0;

  initial begin
    #500_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    tick(3);
    check("rst_we", 32'(we), 32'd0);
    check("rst_waddr", 32'(waddr), 32'd0);
    check("rst_wdata", 32'(wdata), 32'd0);
    check("rst_hold", 32'(hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick(1);

    // Two-word frame preceded by noise bytes
    we0 = we_cnt; d0 = done_cnt;
    send(8'h00); send(8'h3C);
    check("noise_hold", 32'(hold), 32'd0);
    start(10'd1);
    check("frame_hold", 32'(hold), 32'd1);
    word(18'h12345, 6'd0);
    word(18'h2ABCD, 6'd0);
    finish_frame();
    tick(3);
    check("f1_we_count", 32'(we_cnt - we0), 32'd2);
    check("f1_done_count", 32'(done_cnt - d0), 32'd1);
    check("f1_err", 32'(err), 32'd0);
    check("f1_hold", 32'(hold), 32'd0);
    check("f1_pending", 32'(exp_q.size()), 32'd0);

    // Bad count high byte
    we0 = we_cnt; d0 = done_cnt;
    send(8'hA5); send(8'h04); send(8'h00);
    tick(2);
    check("cnt_err", 32'(err), 32'd1);
    check("cnt_hold", 32'(hold), 32'd0);
    check("cnt_we", 32'(we_cnt - we0), 32'd0);
    check("cnt_done", 32'(done_cnt - d0), 32'd0);

`ifdef PROG_LOADER_CSUM_EN
    // Wrong checksum, then a fresh sync clears ERR
    we0 = we_cnt; d0 = done_cnt;
    start(10'd0);
    word(18'h12345, 6'd0);
    send(sum ^ 8'h01);
    tick(2);
    check("csum_err", 32'(err), 32'd1);
    check("csum_we", 32'(we_cnt - we0), 32'd1);
    check("csum_done", 32'(done_cnt - d0), 32'd0);
    d0 = done_cnt;
    start(10'd0);
    check("csum_err_clr", 32'(err), 32'd0);
    word(18'h0BEEF, 6'd0);
    finish_frame();
    tick(3);
    check("csum_ok_done", 32'(done_cnt - d0), 32'd1);
    check("csum_ok_err", 32'(err), 32'd0);
`endif

    // 15-cycle gaps between every byte must not time out
    we0 = we_cnt; d0 = done_cnt;
    gap = 15;
    start(10'd0);
    word(18'h30F0F, 6'h2A);
    finish_frame();
    gap = 0;
    tick(2);
    check("gap_err", 32'(err), 32'd0);
    check("gap_done", 32'(done_cnt - d0), 32'd1);
    check("gap_we", 32'(we_cnt - we0), 32'd1);

    // Silence inside a frame: ERR exactly 16 cycles after the last byte
    d0 = done_cnt;
    send(8'hA5); send(8'h00);
    tick(15);
    check("tmo_early_err", 32'(err), 32'd0);
    check("tmo_early_hold", 32'(hold), 32'd1);
    tick(1);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_hold", 32'(hold), 32'd0);
    check("tmo_done", 32'(done_cnt - d0), 32'd0);

    // Maximum frame, one byte every cycle
    we0 = we_cnt; d0 = done_cnt;
    start(10'h3FF);
    for (int i = 0; i < 1024; i++) word(18'((i * 2731 + 5) & 'h3FFFF), 6'(i));
    finish_frame();
    tick(4);
    check("big_we_count", 32'(we_cnt - we0), 32'd1024);
    check("big_done", 32'(done_cnt - d0), 32'd1);
    check("big_err", 32'(err), 32'd0);
    check("big_last_addr", 32'(waddr), 32'd1023);
    check("big_pending", 32'(exp_q.size()), 32'd0);

    // Reset after the second data byte aborts silently
    we0 = we_cnt; d0 = done_cnt;
    start(10'd1);
    send(8'h01); send(8'h23);
    rst = 1'b1;
    tick(1);
    check("mid_rst_we", 32'(we), 32'd0);
    check("mid_rst_waddr", 32'(waddr), 32'd0);
    check("mid_rst_wdata", 32'(wdata), 32'd0);
    check("mid_rst_hold", 32'(hold), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    send(8'h45);
    tick(2);
    check("post_rst_hold", 32'(hold), 32'd0);
    check("post_rst_we", 32'(we_cnt - we0), 32'd0);
    check("post_rst_done", 32'(done_cnt - d0), 32'd0);
    start(10'd0);
    word(18'h1C3A5, 6'd0);
    check("we_latency", 32'(we), 32'd1);
    finish_frame();
    tick(3);
    check("reload_done", 32'(done_cnt - d0), 32'd1);
    check("reload_err", 32'(err), 32'd0);
    check("reload_we", 32'(we_cnt - we0), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
